// File: rtl/aes_key_expand_if.sv
// Handshake and data bundle between the AES-128 key expander and its round-key consumer.
// The requester drives start/key_in/rk_ready; the expander returns the round-key stream.
interface aes_key_expand_if;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  round_key, round_idx, rk_valid, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output round_key, round_idx, rk_valid, busy, done
    );
endinterface

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams round keys 0..10 over a valid/ready handshake,
// one round per accepted key, using a single SubWord S-box row.
module s_box (
    input  logic [31:0] row_in,
    output logic [31:0] row_out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0); x^(2^k-1) chain then one squaring.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < 6; i++) begin
            r = gf_mul(gf_mul(r, r), x);
        end
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign row_out = {sub_byte(row_in[31:24]), sub_byte(row_in[23:16]),
                      sub_byte(row_in[15:8]),  sub_byte(row_in[7:0])};
endmodule

module aes_key_expand (
    input  logic              clk,
    input  logic              rst_n,
    aes_key_expand_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] round_key_q, round_key_d;
    logic [3:0]   round_idx_q, round_idx_d;
    logic         rk_valid_q, rk_valid_d;

    logic [31:0]  sub_in_s, sub_out_s, temp_s;
    logic [31:0]  w0_s, w1_s, w2_s, w3_s;
    logic         handshake_s, last_s;

    function automatic logic [7:0] rcon_for_round(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign sub_in_s = {round_key_q[23:0], round_key_q[31:24]};

    s_box u_s_box (
        .row_in  (sub_in_s),
        .row_out (sub_out_s)
    );

    assign temp_s = sub_out_s ^ {rcon_for_round(round_idx_q + 4'd1), 24'h000000};
    assign w0_s   = round_key_q[127:96] ^ temp_s;
    assign w1_s   = round_key_q[95:64]  ^ w0_s;
    assign w2_s   = round_key_q[63:32]  ^ w1_s;
    assign w3_s   = round_key_q[31:0]   ^ w2_s;

    assign handshake_s = rk_valid_q & bus.rk_ready;
    assign last_s      = (round_idx_q == 4'd10);

    // Next-state: load on start in IDLE, advance per handshake, drop back after round 10.
    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        round_idx_d = round_idx_q;
        rk_valid_d  = rk_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    round_key_d = bus.key_in;
                    round_idx_d = 4'd0;
                    rk_valid_d  = 1'b1;
                    state_d     = ST_EXPAND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                if (handshake_s && last_s) begin
                    rk_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end else if (handshake_s) begin
                    round_key_d = {w0_s, w1_s, w2_s, w3_s};
                    round_idx_d = round_idx_q + 4'd1;
                end else begin
                    state_d = ST_EXPAND;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rk_valid_d = 1'b0;
            end
        endcase
    end

    // State and round-key registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            round_key_q <= 128'h0;
            round_idx_q <= 4'd0;
            rk_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            round_idx_q <= round_idx_d;
            rk_valid_q  <= rk_valid_d;
        end
    end

    assign bus.round_key = round_key_q;
    assign bus.round_idx = round_idx_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_EXPAND) & handshake_s & last_s;
endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port `clk`, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port `rst_n`, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port `start`, input, 1 bit, SHALL request expansion of `key_in`; it is sampled only in IDLE.
REQ-005 Port `key_in`, input, 128 bits, SHALL be the cipher key, word w0 = [127:96] … w3 = [31:0].
REQ-006 Port `rk_ready`, input, 1 bit, SHALL indicate that the downstream round stage accepts `round_key` this cycle.
REQ-007 Port `round_key`, output, 128 bits, SHALL carry the current round key, with the same word order as `key_in`.
REQ-008 Port `round_idx`, output, 4 bits, SHALL carry the round number (0–10) of `round_key`.
REQ-009 Port `rk_valid`, output, 1 bit, SHALL indicate that `round_key` and `round_idx` are valid.
REQ-010 Port `busy`, output, 1 bit, SHALL be high in every state except IDLE.
REQ-011 Port `done`, output, 1 bit, SHALL pulse for one cycle on the round-10 handshake.

Function
REQ-012 The block SHALL contain exactly one instance of the existing `s_box` module (32-bit `row_in` to `row_out`, combinational) to compute SubWord.
REQ-013 The state machine SHALL have exactly two states: IDLE and EXPAND.
REQ-014 In IDLE with `start`=1, the block SHALL on the next edge:
- latch `key_in` into the key register;
- set `round_idx`=0 and `rk_valid`=1;
- enter EXPAND.
REQ-015 The block SHALL complete the handshake on any cycle in which `rk_valid`=1 and `rk_ready`=1.
REQ-016 In EXPAND with `round_idx`<10, a handshake SHALL advance on the next edge to the next key:
- temp = s_box({w3[23:0], w3[31:24]}) XOR {rcon[round_idx+1], 24'h0};
- w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2';
- `round_idx` increments by 1.
REQ-017 The rcon sequence for rounds 1–10 SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex), taken from a 10-entry constant table indexed by round.
REQ-018 With `rk_valid`=1 and `rk_ready`=0 (stall), the block SHALL hold `round_key`, `round_idx` and `rk_valid` unchanged for any number of cycles.
REQ-019 On the round-10 handshake, the block SHALL:
- assert `done` combinationally in that same cycle;
- on the next edge clear `rk_valid` and return to IDLE;
- leave `round_key`/`round_idx` holding their round-10 values.
REQ-020 `start` asserted while `busy`=1 SHALL be ignored, and `key_in` changes while busy SHALL have no effect.
REQ-021 With `rk_ready` held high, the block SHALL have these latencies:
- first key valid 1 cycle after `start`;
- 11 consecutive valid cycles (rounds 0–10);
- `busy` high for exactly 11 cycles.
REQ-022 The block SHALL accept a `start` in the first IDLE cycle after `done`, with no dead cycle beyond return to IDLE.
REQ-023 The block SHALL produce no X on any output after reset release, regardless of `key_in`.

Reset
REQ-024 Assertion of `rst_n`=0 SHALL immediately (asynchronously) force:
- state IDLE;
- `round_key`=0 and `round_idx`=0;
- `rk_valid`=0, `busy`=0, `done`=0.
REQ-025 Reset asserted mid-EXPAND SHALL abandon the expansion, and the next `start` after release SHALL restart from round 0.
REQ-026 The block SHALL sample `start` only on edges where `rst_n`=1.

Verification
REQ-027 FIPS-197 key, `rk_ready`=1: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, `start` pulse -> round 0 key equals `key_in`; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `done`=1; exactly 11 `rk_valid` cycles.
REQ-028 All-zero key: `key_in`=0 -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 Stall: drop `rk_ready` for 3 cycles at `round_idx`=4 -> outputs frozen at round 4; sequence resumes at round 5; final keys identical to REQ-027.
REQ-030 Busy start: pulse `start` with a different key at `round_idx`=6 -> ignored; round-10 key still matches the first key.
REQ-031 Reset mid-run: `rst_n`=0 at `round_idx`=3 -> all outputs 0 immediately; after release with a new `start`, `round_idx` restarts at 0.
REQ-032 Back-to-back: `start` in the cycle after `done` -> new round 0 key valid on the following cycle.
